// File: rtl/fp_minmax_pipe_if.sv
// Operand/result handshake bundle for fp_minmax_pipe, plus the sticky invalid flag controls.
// master = producer/consumer side (bench or parent), slave = the min/max pipeline.
interface fp_minmax_pipe_if #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
);
    localparam int FP_W = SIGN_W + EXPO_W + MANT_W;

    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] in_a;
    logic [FP_W-1:0] in_b;
    logic            in_op_max;
    logic            out_valid;
    logic            out_ready;
    logic [FP_W-1:0] out_res;
    logic            out_nv;
    logic            nv_sticky;
    logic            nv_clr;

    // Both sides use valid/ready: a transfer happens on the rising edge where
    // valid && ready are both high; valid may not depend on ready, and the
    // payload must stay constant while valid is high and ready is low.
    modport master (
        output in_valid, in_a, in_b, in_op_max, out_ready, nv_clr,
        input  in_ready, out_valid, out_res, out_nv, nv_sticky
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op_max, out_ready, nv_clr,
        output in_ready, out_valid, out_res, out_nv, nv_sticky
    );
endinterface

// File: rtl/fp_minmax_pipe.sv
// Two-stage IEEE-style minimumNumber/maximumNumber with valid/ready flow control
// and a sticky invalid-operation flag.
module fp_minmax_pipe #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic           clk,
    input  logic           rst,
    fp_minmax_pipe_if.slave bus
);
    localparam int FP_W  = SIGN_W + EXPO_W + MANT_W;
    localparam int MAG_W = EXPO_W + MANT_W;
    localparam logic [FP_W-1:0] CANON_QNAN =
        {{SIGN_W{1'b0}}, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    function automatic logic f_is_nan(input logic [FP_W-1:0] x);
        return (&x[MAG_W-1:MANT_W]) && (|x[MANT_W-1:0]);
    endfunction

    function automatic logic f_is_snan(input logic [FP_W-1:0] x);
        return f_is_nan(x) && !x[MANT_W-1];
    endfunction

    logic            r_s1_valid;
    logic [FP_W-1:0] r_s1_a;
    logic [FP_W-1:0] r_s1_b;
    logic            r_s1_op_max;
    logic            r_s1_a_nan;
    logic            r_s1_b_nan;
    logic            r_s1_a_snan;
    logic            r_s1_b_snan;
    logic            r_s1_a_lt_b;
    logic            r_s2_valid;
    logic [FP_W-1:0] r_s2_res;
    logic            r_s2_nv;
    logic            r_nv_sticky;

    logic            w_s2_load;
    logic            w_in_ready;
    logic            w_in_fire;
    logic            w_out_valid;
    logic            w_out_fire;
    logic            w_a_lt_b;
    logic [FP_W-1:0] w_res;
    logic            w_nv;

    assign w_s2_load   = !r_s2_valid || bus.out_ready;
    assign w_in_ready  = !rst && (!r_s1_valid || w_s2_load);
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_out_valid = r_s2_valid && !rst;
    assign w_out_fire  = w_out_valid && bus.out_ready;

    // Sign-magnitude total order: differing signs mean the negative one is
    // smaller (so -0 < +0); negative values order by reversed magnitude.
    always_comb begin
        w_a_lt_b = 1'b0;
        if (bus.in_a[FP_W-1] != bus.in_b[FP_W-1]) begin
            w_a_lt_b = bus.in_a[FP_W-1];
        end else if (bus.in_a[FP_W-1]) begin
            w_a_lt_b = bus.in_a[MAG_W-1:0] > bus.in_b[MAG_W-1:0];
        end else begin
            w_a_lt_b = bus.in_a[MAG_W-1:0] < bus.in_b[MAG_W-1:0];
        end
    end

    always_comb begin
        w_res = r_s1_a;
        w_nv  = r_s1_a_snan || r_s1_b_snan;
        if (r_s1_a_nan && r_s1_b_nan) begin
            w_res = CANON_QNAN;
        end else if (r_s1_a_nan) begin
            w_res = r_s1_b;
        end else if (r_s1_b_nan) begin
            w_res = r_s1_a;
        end else if (r_s1_a_lt_b) begin
            w_res = r_s1_op_max ? r_s1_b : r_s1_a;
        end else begin
            // Equal operands fall here too and return A.
            w_res = r_s1_op_max ? r_s1_a : r_s1_b;
            if (r_s1_a == r_s1_b) w_res = r_s1_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_op_max <= 1'b0;
            r_s1_a_nan  <= 1'b0;
            r_s1_b_nan  <= 1'b0;
            r_s1_a_snan <= 1'b0;
            r_s1_b_snan <= 1'b0;
            r_s1_a_lt_b <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid  <= 1'b1;
            r_s1_a      <= bus.in_a;
            r_s1_b      <= bus.in_b;
            r_s1_op_max <= bus.in_op_max;
            r_s1_a_nan  <= f_is_nan(bus.in_a);
            r_s1_b_nan  <= f_is_nan(bus.in_b);
            r_s1_a_snan <= f_is_snan(bus.in_a);
            r_s1_b_snan <= f_is_snan(bus.in_b);
            r_s1_a_lt_b <= w_a_lt_b;
        end else if (w_s2_load) begin
            r_s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_nv    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res <= w_res;
                r_s2_nv  <= w_nv;
            end
        end
    end

    // A flagged result leaving the block outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nv_sticky <= 1'b0;
        end else if (w_out_fire && r_s2_nv) begin
            r_nv_sticky <= 1'b1;
        end else if (bus.nv_clr) begin
            r_nv_sticky <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_res   = r_s2_res;
    assign bus.out_nv    = r_s2_nv;
    assign bus.nv_sticky = r_nv_sticky;
endmodule

// File: tb/tb_fp_minmax_pipe.sv
// Directed bench for fp_minmax_pipe: scoreboard queue filled on input transfer,
// drained by an independent output monitor.
module tb_fp_minmax_pipe;
  localparam int FP_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_minmax_pipe_if ifc ();

  fp_minmax_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [FP_W:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge after a negedge with valid && ready.
  initial begin
    logic [FP_W:0] e;
    forever begin
      @(negedge clk);
      if (!rst && ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got res=%h nv=%b with nothing expected",
                   ifc.out_res, ifc.out_nv);
        end else begin
          e = exp_q.pop_front();
          check("out_res", 64'(ifc.out_res), 64'(e[FP_W-1:0]));
          check("out_nv", 64'(ifc.out_nv), 64'(e[FP_W]));
        end
      end
    end
  end

  task automatic send(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b, input logic op_max,
                      input logic [FP_W-1:0] exp_res, input logic exp_nv);
    bit ok = 0;
    ifc.in_a      = a;
    ifc.in_b      = b;
    ifc.in_op_max = op_max;
    ifc.in_valid  = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ifc.in_ready) ok = 1;
    end
    if (!ok) begin
      check("send_timeout", 64'd0, 64'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    exp_q.push_back({exp_nv, exp_res});
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !ifc.out_valid) done = 1;
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [FP_W-1:0] bp_a[3]   = '{32'hBF800000, 32'hC0400000, 32'h7F800000};
  logic [FP_W-1:0] bp_b[3]   = '{32'h3F800000, 32'hC0000000, 32'h3F800000};
  logic            bp_op[3]  = '{1'b0, 1'b1, 1'b1};
  logic [FP_W-1:0] bp_exp[3] = '{32'hBF800000, 32'hC0000000, 32'h7F800000};

  initial begin
    int idx;
    bit acc;
    bit held_seen;
    bit ok;
    logic [FP_W-1:0] held;

    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_a = '0;
    ifc.in_b = '0;
    ifc.in_op_max = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.nv_clr = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    check("rst_out_res", 64'(ifc.out_res), 64'd0);
    check("rst_out_nv", 64'(ifc.out_nv), 64'd0);
    check("rst_nv_sticky", 64'(ifc.nv_sticky), 64'd0);

    // Latency: transfer edge, one more edge, then out_valid.
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h3F800000, 1'b0);
    check("lat_not_yet", 64'(ifc.out_valid), 64'd0);
    tick();
    check("lat_valid", 64'(ifc.out_valid), 64'd1);
    check("lat_res", 64'(ifc.out_res), 64'h3F800000);
    wait_drain();

    // Back-to-back directed vectors, op changing pair to pair.
    send(32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 1'b0);
    send(32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0);
    send(32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0);
    send(32'h7FC00000, 32'h40400000, 1'b0, 32'h40400000, 1'b0);
    send(32'h40400000, 32'h7FC00001, 1'b1, 32'h40400000, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
    send(32'hC0000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0);
    wait_drain();
    check("sticky_quiet", 64'(ifc.nv_sticky), 64'd0);

    send(32'h7F800001, 32'h40400000, 1'b0, 32'h40400000, 1'b1);
    wait_drain();
    check("sticky_set", 64'(ifc.nv_sticky), 64'd1);
    send(32'h7FC00000, 32'h7F800001, 1'b0, 32'h7FC00000, 1'b1);
    send(32'hFFC00000, 32'h7FC12345, 1'b1, 32'h7FC00000, 1'b0);
    wait_drain();

    // Backpressure: 3 pairs offered over 4 stalled cycles.
    ifc.out_ready = 1'b0;
    idx = 0;
    held_seen = 0;
    held = '0;
    for (int c = 0; c < 4; c++) begin
      ifc.in_valid = (idx < 3);
      if (idx < 3) begin
        ifc.in_a = bp_a[idx];
        ifc.in_b = bp_b[idx];
        ifc.in_op_max = bp_op[idx];
      end
      @(negedge clk);
      acc = ifc.in_valid && ifc.in_ready;
      if (acc) exp_q.push_back({1'b0, bp_exp[idx]});
      if (ifc.out_valid) begin
        if (!held_seen) begin
          held = ifc.out_res;
          held_seen = 1;
        end else begin
          check("stall_hold", 64'(ifc.out_res), 64'(held));
        end
      end
      tick();
      if (acc) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready", 64'(ifc.in_ready), 64'd0);
    check("bp_out_valid", 64'(ifc.out_valid), 64'd1);
    check("bp_held_first", 64'(ifc.out_res), 64'(bp_exp[0]));
    ifc.out_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        exp_q.push_back({1'b0, bp_exp[idx]});
        ok = 1;
      end
      tick();
    end
    ifc.in_valid = 1'b0;
    if (!ok) check("bp_third_timeout", 64'd0, 64'd1);
    wait_drain();

    // Clear alone, then clear coinciding with a flagged output transfer.
    ifc.nv_clr = 1'b1;
    tick();
    ifc.nv_clr = 1'b0;
    check("clr_alone_a", 64'(ifc.nv_sticky), 64'd0);
    send(32'h7F800001, 32'h40400000, 1'b1, 32'h40400000, 1'b1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ifc.out_valid) ok = 1;
    end
    if (!ok) check("clr_wait_timeout", 64'd0, 64'd1);
    ifc.nv_clr = 1'b1;
    tick();
    check("set_beats_clr", 64'(ifc.nv_sticky), 64'd1);
    tick();
    ifc.nv_clr = 1'b0;
    check("clr_alone_b", 64'(ifc.nv_sticky), 64'd0);
    wait_drain();

    // Reset with two transactions held in the pipe, inputs offered during reset.
    send(32'hFF800001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b1);
    wait_drain();
    check("pre_rst_sticky", 64'(ifc.nv_sticky), 64'd1);
    ifc.out_ready = 1'b0;
    send(32'h7F800001, 32'h40000000, 1'b0, 32'h40000000, 1'b1);
    send(32'h40000000, 32'h40400000, 1'b1, 32'h40400000, 1'b0);
    rst = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_a = 32'h41000000;
    ifc.in_b = 32'h41100000;
    ifc.in_op_max = 1'b1;
    tick();
    check("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("mid_rst_sticky", 64'(ifc.nv_sticky), 64'd0);
    check("mid_rst_out_res", 64'(ifc.out_res), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(ifc.in_ready), 64'd1);
    ifc.out_ready = 1'b1;
    repeat (6) tick();
    check("post_rst_idle", 64'(ifc.out_valid), 64'd0);
    send(32'hC1200000, 32'hC1100000, 1'b0, 32'hC1200000, 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
